fwd_source_pipe: RTL
====================

# fwd_source_pipe

Producer side of the register-forwarding interface. Owns the EX and MEM pipeline registers of the in-order core and drives the two `data_fwd_t` packets, `ex_stage_o` and `mem_stage_o`, consumed by every per-operand forwarder. It also:
- takes the OR-ed load-use hazard flags back from those forwarders and inserts bubbles;
- stalls the pipe while a load waits for data memory;
- produces the register-file write-back strobe.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk_i`  input  1  core clock; all state updates on the rising edge.
- `rst_ni`  input  1  reset, asynchronous, active-low.
- `issue_valid_i`  input  1  decoded instruction offered to EX.
- `issue_rd_i`  input  5  its destination register.
- `issue_rf_wr_en_i`  input  1  instruction writes the register file.
- `issue_mem_read_i`  input  1  instruction is a load.
- `issue_ready_o`  output  1  offered instruction accepted this cycle.
- `load_use_hazard_i`  input  1  OR of all forwarders' load-use flags.
- `flush_i`  input  1  branch resolved taken in EX; kill the offered instruction.
- `ex_result_i`  input  32  combinational EX result (ALU value or load address) for the instruction in EX.
- `ex_stage_o`  output  `data_fwd_t`  EX forwarding packet.
- `mem_stage_o`  output  `data_fwd_t`  MEM forwarding packet.
- `dmem_req_o`  output  1  load request.
- `dmem_addr_o`  output  32  load address.
- `dmem_rvalid_i`  input  1  load data valid.
- `dmem_rdata_i`  input  32  load data.
- `mem_stall_o`  output  1  pipeline frozen waiting for load data.
- `wb_we_o`  output  1  register-file write strobe.
- `wb_rd_o`  output  5  write-back destination register.
- `wb_data_o`  output  32  write-back data.
- `retired_cnt_o`  output  `CNT_W`  count of retired valid instructions.
- `protocol_err_o`  output  1  sticky; set by an unexpected `dmem_rvalid_i`.

## Operation
- **EX register** fields: `valid`, `rd`, `rf_wr_en`, `mem_read`.
- **`ex_stage_o`**: EX register fields plus `rd_data = ex_result_i`.
- **MEM register** fields: `valid`, `rd`, `rf_wr_en`, `mem_read`, `data`. `data` holds the captured `ex_result_i`.
- **`mem_stage_o`**: MEM register fields, with `rd_data` selected as follows:
  - `dmem_rdata_i` when `mem_read && dmem_rvalid_i`;
  - otherwise the MEM register `data`.
- **Stall and advance:**
  - `mem_stall_o = mem.valid && mem.mem_read && !dmem_rvalid_i`.
  - `advance = !mem_stall_o`.
- **Retire and write-back:**
  - `retire = mem.valid && !mem_stall_o`.
  - `wb_we_o = retire && mem.rf_wr_en`.
  - `wb_rd_o = mem.rd`.
  - `wb_data_o = mem_stage_o.rd_data`.
  - `wb_we_o` is never asserted for `rd == 0`.
- **`issue_ready_o`** = `advance && !load_use_hazard_i && !flush_i`.
- **On advance:**
  - MEM loads from EX.
  - EX loads the issued instruction when `issue_ready_o && issue_valid_i`; otherwise EX loads a bubble (`valid = 0`, other fields don't-care).
- **On stall:** EX and MEM hold all fields.
- **Load request:** `dmem_req_o = ex.valid && ex.mem_read && advance`, asserted exactly once per load; `dmem_addr_o = ex_result_i`.
- **FSM** (`RUN`, `LOAD_WAIT`):
  - `RUN` → `LOAD_WAIT` when MEM holds a load and `dmem_rvalid_i = 0`.
  - `LOAD_WAIT` → `RUN` on `dmem_rvalid_i`.
  - `mem_stall_o` is asserted in every `LOAD_WAIT` cycle.
- **Counter:** `retired_cnt_o` increments on `retire` and wraps modulo 2^`CNT_W`.
- **Protocol error:** `dmem_rvalid_i` while MEM does not hold a valid load sets `protocol_err_o`. The data is ignored. The flag clears only on reset.

## Timing
- **Reset values:**
  - EX and MEM `valid` = 0 (all other EX/MEM fields 0);
  - FSM = `RUN`;
  - `retired_cnt_o` = 0;
  - `protocol_err_o` = 0;
  - consequently `wb_we_o`, `dmem_req_o` and `mem_stall_o` are 0 and `issue_ready_o` = 1.
- **Latency:**
  - Issue to EX: 1 cycle.
  - EX to MEM: 1 cycle.
  - A non-load instruction retires 2 cycles after issue.
  - A load retires in the cycle `dmem_rvalid_i` is high. The earliest is the first cycle in MEM, i.e. zero wait states.
- **Simultaneous events:**
  - `flush_i` and `load_use_hazard_i` together: a single bubble is inserted, `issue_ready_o = 0`.
  - `flush_i` during a stall: no effect on EX/MEM. The flush must be re-presented by the fetch side, which is frozen by `mem_stall_o`.
  - A load-use hazard during a stall is ignored until `advance`.
- **Reset mid-operation:** asynchronous clear of all state. An outstanding load response arriving after reset sets `protocol_err_o`.
- **Outputs:** all forwarding packets and `wb_*` outputs are combinational from registers plus `ex_result_i` / `dmem_*`. There is no extra register stage.

## Test plan
- **Back-to-back ALU ops.** Issue writes x5 = 0x11 then x6 = 0x22. Required:
  - `ex_stage_o.rd = 5` in cycle 1;
  - `mem_stage_o.rd_data = 0x11` in cycle 2;
  - `wb_we_o` for x5 in cycle 2 and for x6 in cycle 3;
  - `retired_cnt_o = 2`.
- **Load-use.** Load x7, then `load_use_hazard_i = 1` for one cycle. Required: `issue_ready_o = 0`, a bubble in EX, the dependent instruction accepted the following cycle, and exactly one `dmem_req_o` pulse.
- **Load with 3 wait states.** Required: `mem_stall_o` high for 3 cycles and EX/MEM held. When rvalid arrives with 0xDEADBEEF, `wb_data_o = 0xDEADBEEF` and `mem_stage_o.rd_data = 0xDEADBEEF` in the same cycle.
- **Flush.** `flush_i` with a valid issue. Required: the next EX is a bubble, no `wb_we_o` for that instruction, and the counter unchanged.
- **Reset with a load in `LOAD_WAIT`**, then rvalid. Required: all outputs at their reset values and `protocol_err_o = 1` after the rvalid.
- **Counter wrap.** With `CNT_W = 4`, retire 17 instructions. Required: `retired_cnt_o = 1`.

Source files
------------

// File: rtl/fwd_source_pipe_if.sv
// Forwarding packet type and the bundled handshake/bus signals of fwd_source_pipe.
// master = the pipe (producer of forwarding packets), slave = decode/forwarders/dmem side.
package fwd_source_pipe_pkg;
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        rf_wr_en;
        logic        mem_read;
        logic [31:0] rd_data;
    } data_fwd_t;
endpackage

interface fwd_source_pipe_if;
    import fwd_source_pipe_pkg::*;

    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        issue_rf_wr_en_i;
    logic        issue_mem_read_i;
    logic        issue_ready_o;
    logic        load_use_hazard_i;
    logic        flush_i;
    logic [31:0] ex_result_i;
    data_fwd_t   ex_stage_o;
    data_fwd_t   mem_stage_o;
    logic        dmem_req_o;
    logic [31:0] dmem_addr_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        mem_stall_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    modport master (
        input  issue_valid_i, issue_rd_i, issue_rf_wr_en_i, issue_mem_read_i,
        input  load_use_hazard_i, flush_i, ex_result_i,
        input  dmem_rvalid_i, dmem_rdata_i,
        output issue_ready_o, ex_stage_o, mem_stage_o,
        output dmem_req_o, dmem_addr_o, mem_stall_o,
        output wb_we_o, wb_rd_o, wb_data_o
    );

    modport slave (
        output issue_valid_i, issue_rd_i, issue_rf_wr_en_i, issue_mem_read_i,
        output load_use_hazard_i, flush_i, ex_result_i,
        output dmem_rvalid_i, dmem_rdata_i,
        input  issue_ready_o, ex_stage_o, mem_stage_o,
        input  dmem_req_o, dmem_addr_o, mem_stall_o,
        input  wb_we_o, wb_rd_o, wb_data_o
    );
endinterface

// File: rtl/fwd_source_pipe.sv
// EX/MEM pipeline registers of the in-order core: drives the forwarding packets,
// inserts load-use/flush bubbles, freezes on outstanding loads and produces write-back.
module fwd_source_pipe
    import fwd_source_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    fwd_source_pipe_if.master  bus,
    output logic [CNT_W-1:0]   retired_cnt_o,
    output logic               protocol_err_o
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rf_wr_en;
        logic       mem_read;
    } ex_reg_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        rf_wr_en;
        logic        mem_read;
        logic [31:0] data;
    } mem_reg_t;

    typedef enum logic {
        RUN,
        LOAD_WAIT
    } state_t;

    state_t             state_q, state_d;
    ex_reg_t            ex_q, ex_d;
    mem_reg_t           mem_q, mem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               perr_q, perr_d;

    logic               mem_is_load;
    logic               load_done;
    logic               mem_stall;
    logic               advance;
    logic               retire;
    logic               issue_ready;
    logic               issue_take;
    logic [31:0]        mem_fwd_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        mem_is_load  = mem_q.valid && mem_q.mem_read;
        load_done    = mem_q.mem_read && bus.dmem_rvalid_i;
        mem_stall    = mem_is_load && !bus.dmem_rvalid_i;
        advance      = !mem_stall;
        retire       = mem_q.valid && advance;
        issue_ready  = advance && !bus.load_use_hazard_i && !bus.flush_i;
        issue_take   = issue_ready && bus.issue_valid_i;
        mem_fwd_data = load_done ? bus.dmem_rdata_i : mem_q.data;
    end

    // LOAD_WAIT is entered only with a load held in MEM, so the stall term
    // above already covers every LOAD_WAIT cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:       if (mem_is_load && !bus.dmem_rvalid_i) state_d = LOAD_WAIT;
            LOAD_WAIT: if (bus.dmem_rvalid_i)                 state_d = RUN;
            default:                                          state_d = RUN;
        endcase
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        if (advance) begin
            mem_d.valid    = ex_q.valid;
            mem_d.rd       = ex_q.rd;
            mem_d.rf_wr_en = ex_q.rf_wr_en;
            mem_d.mem_read = ex_q.mem_read;
            mem_d.data     = bus.ex_result_i;
            if (issue_take) begin
                ex_d.valid    = 1'b1;
                ex_d.rd       = bus.issue_rd_i;
                ex_d.rf_wr_en = bus.issue_rf_wr_en_i;
                ex_d.mem_read = bus.issue_mem_read_i;
            end else begin
                ex_d = '0;
            end
        end
    end

    // A response with no load waiting in MEM (including one left over from
    // before a reset) is dropped and latched as a protocol error.
    always_comb begin
        cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;
        perr_d = perr_q || (bus.dmem_rvalid_i && !mem_is_load);
    end

    always_comb begin
        bus.ex_stage_o.valid     = ex_q.valid;
        bus.ex_stage_o.rd        = ex_q.rd;
        bus.ex_stage_o.rf_wr_en  = ex_q.rf_wr_en;
        bus.ex_stage_o.mem_read  = ex_q.mem_read;
        bus.ex_stage_o.rd_data   = bus.ex_result_i;

        bus.mem_stage_o.valid    = mem_q.valid;
        bus.mem_stage_o.rd       = mem_q.rd;
        bus.mem_stage_o.rf_wr_en = mem_q.rf_wr_en;
        bus.mem_stage_o.mem_read = mem_q.mem_read;
        bus.mem_stage_o.rd_data  = mem_fwd_data;

        bus.issue_ready_o = issue_ready;
        bus.dmem_req_o    = ex_q.valid && ex_q.mem_read && advance;
        bus.dmem_addr_o   = bus.ex_result_i;
        bus.mem_stall_o   = mem_stall;

        bus.wb_we_o   = retire && mem_q.rf_wr_en && (mem_q.rd != 5'd0);
        bus.wb_rd_o   = mem_q.rd;
        bus.wb_data_o = mem_fwd_data;
    end

    assign retired_cnt_o  = cnt_q;
    assign protocol_err_o = perr_q;

endmodule
